rand_range_gen: RTL

Parametrised pseudo-random source built around a configurable-tap Fibonacci LFSR. It produces uniformly distributed values in a caller-supplied inclusive range [Lo, Hi] through a request/valid handshake, using mask-and-reject sampling with a bounded retry count. It replaces fixed 16-bit LFSR use in the game logic, for example pipe gap height and spawn jitter.

---
 rtl/rng_pkg.sv | 25 ++
 rtl/lfsr_core.sv | 28 ++
 rtl/rand_range_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the range-limited random source.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MASK,
    DRAW
  } rng_state_t;

  localparam logic [15:0] RNG_DEFAULT_TAPS16 = 16'hB400;
  localparam logic [15:0] RNG_DEFAULT_SEED16 = 16'hACE1;

  // Smear the top set bit downward: smallest all-ones value >= span.
  function automatic logic [31:0] msb_fill(input logic [31:0] span);
    logic [31:0] m;
    m = span;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with seed load; zero seeds map to SEED so the
// register can never lock up at all-zeros.
module lfsr_core
  import rng_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(RNG_DEFAULT_TAPS16),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(RNG_DEFAULT_SEED16)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             advance,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q <= SEED;
    end else if (load) begin
      q <= (load_value == '0) ? SEED : load_value;
    end else if (advance) begin
      q <= {q[WIDTH-2:0], ^(q & TAPS)};
    end
  end

endmodule

// File: rtl/rand_range_gen.sv
// Uniform draw in [Lo, Hi] by mask-and-reject over an LFSR.
// Define RNG_REJECT_COUNT_EN to build the saturating RejectCount counter.
module rand_range_gen
  import rng_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_W = 9,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(RNG_DEFAULT_TAPS16),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(RNG_DEFAULT_SEED16),
  parameter int MAX_RETRY = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             SeedLoad,
  input  logic [WIDTH-1:0] SeedIn,
  input  logic             Req,
  input  logic [OUT_W-1:0] Lo,
  input  logic [OUT_W-1:0] Hi,
  output logic             Busy,
  output logic             Valid,
  output logic [OUT_W-1:0] Value,
  output logic             Err,
  output logic [WIDTH-1:0] State,
  output logic [15:0]      RejectCount
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  rng_state_t state, nxt;

  logic [OUT_W-1:0] lo_q;
  logic [OUT_W-1:0] span_q;
  logic [OUT_W-1:0] mask_q;
  logic [RW-1:0]    retries;
  logic [WIDTH-1:0] q;
  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] res;
  logic             take;
  logic             bad;
  logic             done;
  logic             reject;

  lfsr_core #(
    .WIDTH(WIDTH),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .Clock     (Clock),
    .Reset     (Reset),
    .advance   ((state != IDLE) || Enable),
    .load      (SeedLoad),
    .load_value(SeedIn),
    .q         (q)
  );

  assign cand  = q[OUT_W-1:0] & mask_q;
  assign Busy  = (state != IDLE);
  assign State = q;

  always_comb begin
    nxt    = state;
    take   = 1'b0;
    bad    = 1'b0;
    done   = 1'b0;
    reject = 1'b0;
    res    = '0;
    case (state)
      IDLE: begin
        if (Req) begin
          if (Lo > Hi) begin
            bad = 1'b1;
          end else begin
            take = 1'b1;
            nxt  = MASK;
          end
        end
      end
      MASK: nxt = DRAW;
      DRAW: begin
        if (cand <= span_q) begin
          done = 1'b1;
          res  = lo_q + cand;
          nxt  = IDLE;
        end else if (retries != MAX_R) begin
          reject = 1'b1;
        end else begin
          // cand < 2*(span+1), so folding it down stays in range
          done = 1'b1;
          res  = lo_q + (cand - span_q - OUT_W'(1));
          nxt  = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      Valid   <= 1'b0;
      Err     <= 1'b0;
      Value   <= '0;
      lo_q    <= '0;
      span_q  <= '0;
      mask_q  <= '0;
      retries <= '0;
    end else begin
      state <= nxt;
      Valid <= done | bad;
      if (bad) begin
        Value <= Lo;
        Err   <= 1'b1;
      end else if (done) begin
        Value <= res;
        Err   <= 1'b0;
      end
      if (take) begin
        lo_q    <= Lo;
        span_q  <= Hi - Lo;
        retries <= '0;
      end else if (reject) begin
        retries <= retries + RW'(1);
      end
      if (state == MASK) begin
        mask_q <= OUT_W'(msb_fill(32'(span_q)));
      end
    end
  end

`ifdef RNG_REJECT_COUNT_EN
  logic [15:0] rej_cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rej_cnt <= '0;
    end else if (reject && (rej_cnt != 16'hFFFF)) begin
      rej_cnt <= rej_cnt + 16'd1;
    end
  end

  assign RejectCount = rej_cnt;
`else
  assign RejectCount = '0;
`endif

endmodule
